rr_mux_reg: RTL and testbench
=============================

Name: rr_mux_reg

Overview:
- Parametrised successor to the datapath 4:1 mux. It selects one of NUM_CH valid/ready input channels of width N and presents it on a single registered output.
- Arbitration is round-robin or fixed-priority, chosen at run time.
- Used where several producers share one consumer, for example writeback sources or bus masters feeding a shared 16-bit bus.
- One cycle of latency; sustains one transfer per clock.

Parameters:
- N, 16, data width per channel.
- NUM_CH, 4, number of input channels; legal range 2..16.
- SELW, $clog2(NUM_CH), width of the channel index; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- in_data  input  NUM_CH*N  channel i occupies bits [i*N +: N].
- in_valid  input  NUM_CH  channel i presents data.
- in_ready  output  NUM_CH  channel i's data is accepted this cycle.
- prio_mode  input  1  0 = round-robin, 1 = fixed priority (lowest index wins).
- out_data  output  N  registered selected data.
- out_valid  output  1  out_data/out_sel hold a transfer.
- out_ready  input  1  consumer accepts the output this cycle.
- out_sel  output  SELW  index of the channel that produced out_data.

Behaviour:
- Reset (async assert, synchronous-to-clk deassert handled externally):
  - out_valid=0, out_data=0, out_sel=0.
  - RR pointer ptr=0.
  - in_ready=0 while reset is high.
- load_en = ~out_valid | out_ready. The output register may load this cycle.
- Arbitration is combinational each cycle over in_valid:
  - RR mode: search indices ptr, ptr+1, ..., ptr+NUM_CH-1, all mod NUM_CH. The first valid index wins.
  - Fixed mode: the lowest valid index wins. ptr is ignored.
- Grant g exists iff any in_valid is high.
- in_ready[i] = load_en & grant_exists & (g==i). All other bits are 0 and at most one bit is high.
  - in_ready depends combinationally on out_ready and in_valid. It must not depend on in_ready itself.
- Handshake: an input transfer occurs when in_valid[i] & in_ready[i].
  - Producers hold in_data and in_valid until they receive ready.
- On the clk edge with load_en=1:
  - If grant_exists: out_data<=in_data[g], out_sel<=g, out_valid<=1.
  - Otherwise: out_valid<=0. out_data and out_sel hold their previous values.
- With load_en=0 (stall: out_valid=1, out_ready=0): out_data, out_sel and out_valid hold. No in_ready is asserted.
- Pointer update: only in RR mode and only on an input transfer, ptr<=(g+1) mod NUM_CH.
  - Wrap: g=NUM_CH-1 gives ptr=0.
  - In fixed mode ptr holds.
- Latency: input accepted at edge k appears on out_data/out_valid after edge k. Back-to-back transfers run at full rate while out_ready=1.
- Mode change: prio_mode is sampled combinationally and takes effect on the next arbitration. ptr keeps its value across mode switches.
- Single requester: always granted on the first cycle with load_en=1, regardless of ptr or mode.
- Fairness: in RR mode with all channels continuously valid, grants cycle through indices ptr, ptr+1, and so on. No channel waits more than NUM_CH-1 grants.
- Reset mid-operation: a pending output transfer is dropped (out_valid=0 immediately on reset assertion). ptr returns to 0.
- Non-power-of-two NUM_CH: ptr and g never exceed NUM_CH-1. Modulo wrap is explicit, not a bit-width overflow.

Test Plan:
- Reset: reset=1 with all in_valid=1 → out_valid=0, out_data=0, out_sel=0, in_ready=0000. After release and one edge: out_sel=0, out_data=in_data[0], out_valid=1.
- RR rotation: NUM_CH=4, prio_mode=0, all four valid, out_ready=1, data i=16'hA000+i → out_sel sequence 0,1,2,3,0 on consecutive cycles; in_ready one-hot 0001,0010,0100,1000,0001.
- Fixed priority: prio_mode=1, in_valid=1010 held, out_ready=1 → channel 1 granted every cycle. out_data=data1 and channel 3 starves. Then drop ch1 → channel 3 granted on the next cycle.
- Backpressure: out_valid=1, out_ready=0 for 3 cycles → out_data/out_sel stable and in_ready=0000. Raise out_ready → the held word drains and a new word loads on the same edge.
- Empty/drain: single transfer from channel 2 (ptr was 0), then all in_valid=0 → out_valid drops one cycle after the drain. out_sel stays 2 and ptr=3. The next grant with all valid goes to channel 3.
- Non-power-of-two: NUM_CH=3, all valid → out_sel 0,1,2,0, with no index 3 ever produced. Then assert reset mid-stream → out_valid=0 immediately and ptr=0 after release.

Source files
------------

// File: rtl/rr_mux_reg.sv
// rr_mux_reg: NUM_CH-way valid/ready arbiter feeding a single registered output.
// Arbitration is round-robin (prio_mode=0) or fixed lowest-index priority (prio_mode=1),
// selected at run time. One cycle of latency, one transfer per clock.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   in_data    NUM_CH*N packed channel data, channel i at [i*N +: N]
//   in_valid   per-channel request
//   in_ready   per-channel accept (one-hot or zero)
//   prio_mode  0 = round-robin, 1 = fixed priority
//   out_data   registered selected data
//   out_valid  out_data/out_sel hold a transfer
//   out_ready  consumer accepts the output this cycle
//   out_sel    index of the channel that produced out_data
module rr_mux_reg #(
    parameter int unsigned N      = 16,
    parameter int unsigned NUM_CH = 4,
    localparam int unsigned SELW  = $clog2(NUM_CH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_CH*N-1:0]   in_data,
    input  logic [NUM_CH-1:0]     in_valid,
    output logic [NUM_CH-1:0]     in_ready,
    input  logic                  prio_mode,
    output logic [N-1:0]          out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [SELW-1:0]       out_sel
);

    logic [SELW-1:0] ptr_q, ptr_d;
    logic [SELW-1:0] gnt;
    logic            grant_exists;
    logic            load_en;
    logic            xfer;
    logic [N-1:0]    out_data_q;
    logic [SELW-1:0] out_sel_q;
    logic            out_valid_q;

    assign load_en      = ~out_valid_q | out_ready;
    assign grant_exists = |in_valid;
    assign xfer         = load_en & grant_exists;

    // Search from ptr (RR) or from 0 (fixed); wrap is explicit so non-power-of-two
    // channel counts never produce an index >= NUM_CH.
    always_comb begin
        logic found;
        gnt   = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            int unsigned idx;
            idx = prio_mode ? k : 32'(ptr_q) + k;
            if (idx >= NUM_CH) begin
                idx = idx - NUM_CH;
            end
            if (!found && in_valid[SELW'(idx)]) begin
                gnt   = SELW'(idx);
                found = 1'b1;
            end
        end
    end

    always_comb begin
        in_ready = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            in_ready[i] = ~reset & xfer & (gnt == SELW'(i));
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (xfer && !prio_mode) begin
            ptr_d = (gnt == SELW'(NUM_CH - 1)) ? '0 : gnt + SELW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
        end else begin
            ptr_q <= ptr_d;
            if (load_en) begin
                out_valid_q <= grant_exists;
                // Data and index hold when nothing is granted.
                if (grant_exists) begin
                    out_data_q <= in_data[32'(gnt) * N +: N];
                    out_sel_q  <= gnt;
                end
            end
        end
    end

    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_rr_mux_reg.sv
// Scoreboard bench for rr_mux_reg: a 4-channel instance and a 3-channel instance.
// Stimulus pushes hand-computed expected words; monitors pop on each output handshake.
module tb_rr_mux_reg;

    localparam int unsigned N = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // 4-channel DUT
    logic          reset;
    logic [4*N-1:0] in_data;
    logic [3:0]    in_valid;
    logic [3:0]    in_ready;
    logic          prio_mode;
    logic [N-1:0]  out_data;
    logic          out_valid;
    logic          out_ready;
    logic [1:0]    out_sel;

    // 3-channel DUT
    logic          reset3;
    logic [3*N-1:0] in_data3;
    logic [2:0]    in_valid3;
    logic [2:0]    in_ready3;
    logic          prio_mode3;
    logic [N-1:0]  out_data3;
    logic          out_valid3;
    logic          out_ready3;
    logic [1:0]    out_sel3;

    rr_mux_reg #(.N(N), .NUM_CH(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .prio_mode (prio_mode),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sel   (out_sel)
    );

    rr_mux_reg #(.N(N), .NUM_CH(3)) dut3 (
        .clk       (clk),
        .reset     (reset3),
        .in_data   (in_data3),
        .in_valid  (in_valid3),
        .in_ready  (in_ready3),
        .prio_mode (prio_mode3),
        .out_data  (out_data3),
        .out_valid (out_valid3),
        .out_ready (out_ready3),
        .out_sel   (out_sel3)
    );

    int unsigned passed = 0;
    int unsigned total  = 0;
    logic [17:0] q4[$];  // {sel, data}
    logic [17:0] q3[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Monitors: a word is consumed when out_valid & out_ready at the next rising edge.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (q4.size() == 0) begin
                total++;
                $display("FAIL out4 unexpected word: got sel=%0d data=0x%0h, want none",
                         out_sel, out_data);
            end else begin
                logic [17:0] e;
                e = q4.pop_front();
                check("out4 word", {14'd0, out_sel, out_data}, {14'd0, e});
            end
        end
    end

    always @(negedge clk) begin
        if (!reset3 && out_valid3 && out_ready3) begin
            if (q3.size() == 0) begin
                total++;
                $display("FAIL out3 unexpected word: got sel=%0d data=0x%0h, want none",
                         out_sel3, out_data3);
            end else begin
                logic [17:0] e;
                e = q3.pop_front();
                check("out3 word", {14'd0, out_sel3, out_data3}, {14'd0, e});
            end
        end
    end

    // One cycle on the 4-channel DUT; er is the hand-computed in_ready.
    task automatic cyc4(input logic [3:0] v, input logic m, input logic ordy,
                        input logic [3:0] er);
        in_valid  = v;
        prio_mode = m;
        out_ready = ordy;
        @(negedge clk);
        check("in_ready4", 32'(in_ready), 32'(er));
        for (int i = 0; i < 4; i++) begin
            if (er[i]) q4.push_back({2'(i), 16'hA000 + 16'(i)});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic cyc3(input logic [2:0] v, input logic [2:0] er);
        in_valid3 = v;
        @(negedge clk);
        check("in_ready3", 32'(in_ready3), 32'(er));
        for (int i = 0; i < 3; i++) begin
            if (er[i]) q3.push_back({2'(i), 16'hB000 + 16'(i)});
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset      = 1'b1;
        reset3     = 1'b1;
        in_data    = {16'hA003, 16'hA002, 16'hA001, 16'hA000};
        in_data3   = {16'hB002, 16'hB001, 16'hB000};
        in_valid   = 4'b1111;
        in_valid3  = 3'b000;
        prio_mode  = 1'b0;
        prio_mode3 = 1'b0;
        out_ready  = 1'b1;
        out_ready3 = 1'b1;

        // Reset state with all requests up
        @(posedge clk);
        @(negedge clk);
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst out_data", 32'(out_data), 32'd0);
        check("rst out_sel", 32'(out_sel), 32'd0);
        check("rst in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        reset  = 1'b0;
        reset3 = 1'b0;

        // Round-robin rotation, ptr starts at 0
        cyc4(4'b1111, 1'b0, 1'b1, 4'b0001);
        check("post-rst out_valid", 32'(out_valid), 32'd1);
        check("post-rst out_sel", 32'(out_sel), 32'd0);
        check("post-rst out_data", 32'(out_data), 32'hA000);
        cyc4(4'b1111, 1'b0, 1'b1, 4'b0010);
        cyc4(4'b1111, 1'b0, 1'b1, 4'b0100);
        cyc4(4'b1111, 1'b0, 1'b1, 4'b1000);
        cyc4(4'b1111, 1'b0, 1'b1, 4'b0001);  // ptr now 1

        // Fixed priority: ch1 beats ch3 until it drops; ptr stays 1
        cyc4(4'b1010, 1'b1, 1'b1, 4'b0010);
        cyc4(4'b1010, 1'b1, 1'b1, 4'b0010);
        cyc4(4'b1010, 1'b1, 1'b1, 4'b0010);
        cyc4(4'b1000, 1'b1, 1'b1, 4'b1000);

        // Backpressure holding ch3's word
        for (int s = 0; s < 3; s++) begin
            cyc4(4'b1111, 1'b0, 1'b0, 4'b0000);
            check("stall out_valid", 32'(out_valid), 32'd1);
            check("stall out_sel", 32'(out_sel), 32'd3);
            check("stall out_data", 32'(out_data), 32'hA003);
        end
        // Drain and reload on the same edge; RR resumes from ptr=1
        cyc4(4'b1111, 1'b0, 1'b1, 4'b0010);  // ptr -> 2

        // Empty/drain: steer ptr to 0, then a lone ch2 transfer
        cyc4(4'b1000, 1'b0, 1'b1, 4'b1000);  // ptr -> 0
        cyc4(4'b0100, 1'b0, 1'b1, 4'b0100);  // ptr -> 3
        cyc4(4'b0000, 1'b0, 1'b1, 4'b0000);
        check("drain out_valid", 32'(out_valid), 32'd0);
        check("drain out_sel", 32'(out_sel), 32'd2);
        check("drain out_data", 32'(out_data), 32'hA002);
        cyc4(4'b1111, 1'b0, 1'b1, 4'b1000);  // ptr=3 wins
        cyc4(4'b0000, 1'b0, 1'b1, 4'b0000);
        cyc4(4'b0000, 1'b0, 1'b1, 4'b0000);

        // Non-power-of-two: 3 channels wrap 0,1,2,0
        cyc3(3'b111, 3'b001);
        cyc3(3'b111, 3'b010);
        cyc3(3'b111, 3'b100);
        cyc3(3'b111, 3'b001);  // ch0 word pending, ptr=1

        // Reset mid-stream drops the pending word at once
        reset3 = 1'b1;
        #1;
        check("rst3 out_valid", 32'(out_valid3), 32'd0);
        check("rst3 in_ready", 32'(in_ready3), 32'd0);
        q3.delete();
        @(posedge clk);
        #1;
        reset3 = 1'b0;
        cyc3(3'b111, 3'b001);  // ptr back to 0
        cyc3(3'b110, 3'b010);
        cyc3(3'b000, 3'b000);
        cyc3(3'b000, 3'b000);

        check("q4 drained", 32'(q4.size()), 32'd0);
        check("q3 drained", 32'(q3.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
